// File: rtl/synth_voice_bank.sv
// Multi-voice oscillator bank: octave-divided step, period counter, phase accumulator and mixer.
// Optional first-order delta-sigma 1-bit output is built when SYNTH_PDM_OUT_EN is defined.
module synth_voice_bank #(
  parameter int NUM_VOICES   = 2,
  parameter int DIVIDER_BITS = 7,
  parameter int OCT_BITS     = 3,
  parameter int PERIOD_BITS  = 10,
  parameter int WAVE_BITS    = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      cfg_we,
  input  logic [5:0]                                cfg_addr,
  input  logic [7:0]                                cfg_data,
  output logic [WAVE_BITS+$clog2(NUM_VOICES)-1:0]   sample_out,
  output logic                                      pdm_out
);

  localparam int SUM_BITS = WAVE_BITS + $clog2(NUM_VOICES);
  localparam int HI_BITS  = PERIOD_BITS - 8;
  localparam logic [DIVIDER_BITS-1:0] DIV_ONES = '1;

  logic [PERIOD_BITS-1:0]  r_period [NUM_VOICES];
  logic [OCT_BITS-1:0]     r_oct    [NUM_VOICES];
  logic [1:0]              r_mode   [NUM_VOICES];
  logic [1:0]              r_atten  [NUM_VOICES];
  logic [PERIOD_BITS-1:0]  r_cnt    [NUM_VOICES];
  logic [WAVE_BITS-1:0]    r_phase  [NUM_VOICES];
  logic [DIVIDER_BITS-1:0] r_divCnt;
  logic [SUM_BITS-1:0]     r_sample;

  logic [3:0]              w_wrVoice;
  logic [1:0]              w_wrReg;
  logic                    w_wrValid;
  logic [NUM_VOICES-1:0]   w_sel;
  logic [NUM_VOICES-1:0]   w_strobe;
  logic [NUM_VOICES-1:0]   w_step;
  logic [DIVIDER_BITS-1:0] w_stepMask [NUM_VOICES];
  logic [WAVE_BITS-1:0]    w_tri      [NUM_VOICES];
  logic [WAVE_BITS-1:0]    w_wave     [NUM_VOICES];
  logic [WAVE_BITS-1:0]    w_contrib  [NUM_VOICES];
  logic [SUM_BITS-1:0]     w_sum;

  assign w_wrVoice = cfg_addr[5:2];
  assign w_wrReg   = cfg_addr[1:0];
  assign w_wrValid = cfg_we && ({1'b0, w_wrVoice} < 5'(NUM_VOICES));

  // A voice steps when the low (MAX_OCT - oct) divider bits are all zero; ~oct equals that shift.
  always_comb begin
    w_sel    = '0;
    w_strobe = '0;
    w_step   = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_stepMask[v] = ~(DIV_ONES << (~r_oct[v]));
      w_sel[v]      = w_wrValid && (w_wrVoice == 4'(v));
      w_strobe[v]   = w_sel[v] && (w_wrReg == 2'd2) && cfg_data[7];
      w_step[v]     = (r_divCnt & w_stepMask[v]) == '0;
    end
  end

  always_comb begin
    w_sum = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_wave[v] = '0;
      w_tri[v]  = {r_phase[v][WAVE_BITS-2:0], 1'b0};
      case (r_mode[v])
        2'd0:    w_wave[v] = r_phase[v];
        2'd1:    w_wave[v] = {WAVE_BITS{r_phase[v][WAVE_BITS-1]}};
        2'd2:    w_wave[v] = r_phase[v][WAVE_BITS-1] ? ~w_tri[v] : w_tri[v];
        default: w_wave[v] = '0;
      endcase
      w_contrib[v] = w_wave[v] >> r_atten[v];
      w_sum        = w_sum + SUM_BITS'(w_contrib[v]);
    end
  end

  // Phase-reset strobe overrides a coincident step; period writes only take effect at the next reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_period[v] <= '0;
        r_oct[v]    <= '0;
        r_mode[v]   <= 2'd3;
        r_atten[v]  <= '0;
        r_cnt[v]    <= '0;
        r_phase[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (w_strobe[v]) begin
          r_phase[v] <= '0;
          r_cnt[v]   <= '0;
        end else if (w_step[v]) begin
          if (r_cnt[v] == '0) begin
            r_cnt[v]   <= r_period[v];
            r_phase[v] <= r_phase[v] + 1'b1;
          end else begin
            r_cnt[v] <= r_cnt[v] - 1'b1;
          end
        end
        if (w_sel[v]) begin
          case (w_wrReg)
            2'd0: r_period[v][7:0] <= cfg_data;
            2'd1: r_oct[v] <= cfg_data[OCT_BITS-1:0];
            2'd2: begin
              r_mode[v]  <= cfg_data[1:0];
              r_atten[v] <= cfg_data[3:2];
            end
            default: r_period[v][PERIOD_BITS-1:8] <= cfg_data[HI_BITS-1:0];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_divCnt <= '0;
      r_sample <= '0;
    end else begin
      r_divCnt <= r_divCnt + 1'b1;
      r_sample <= w_sum;
    end
  end

  assign sample_out = r_sample;

`ifdef SYNTH_PDM_OUT_EN
  // The accumulator MSB is the carry of the previous addition, i.e. the registered 1-bit output.
  logic [SUM_BITS:0] r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else begin
      r_acc <= {1'b0, r_acc[SUM_BITS-1:0]} + {1'b0, r_sample};
    end
  end

  assign pdm_out = r_acc[SUM_BITS];
`else
  assign pdm_out = 1'b0;
`endif

endmodule

// File: tb/tb_synth_voice_bank.sv
// Directed bench for synth_voice_bank: mix table on lockstep voices plus multi-cycle sequences.
// Expected PDM duty depends on whether SYNTH_PDM_OUT_EN is defined.
module tb_synth_voice_bank;

  localparam int SW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_we;
  logic [5:0]    cfg_addr;
  logic [7:0]    cfg_data;
  logic [SW-1:0] sample_out;
  logic          pdm_out;

  int checks = 0;
  int errors = 0;
  int tickCount = 0;

  typedef struct {
    int         phase;
    logic [7:0] reg2v0;
    logic [7:0] reg2v1;
    int         expSample;
  } mixVec_t;

  mixVec_t vecs [12];
  int strobeExp [20];
  int edgeTick [3];
  int edgeLevel [3];

  synth_voice_bank dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .sample_out (sample_out),
    .pdm_out    (pdm_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    tickCount++;
  endtask

  task automatic applyStimulus(input logic [5:0] addr, input logic [7:0] data);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // A write to voice 0 is held during reset so reset priority is exercised every time.
  task automatic doReset();
    reset    = 1'b1;
    cfg_we   = 1'b1;
    cfg_addr = 6'd2;
    cfg_data = 8'h00;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    cfg_we    = 1'b0;
    tickCount = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nTrans;
    int prevSample;
    int ones;
    int expOnes;

    vecs[0]  = '{64,  8'h00, 8'h00, 128};
    vecs[1]  = '{64,  8'h00, 8'h02, 192};
    vecs[2]  = '{64,  8'h01, 8'h06, 64};
    vecs[3]  = '{64,  8'h0A, 8'h03, 32};
    vecs[4]  = '{200, 8'h00, 8'h01, 455};
    vecs[5]  = '{200, 8'h02, 8'h0E, 124};
    vecs[6]  = '{200, 8'h05, 8'h08, 177};
    vecs[7]  = '{200, 8'h03, 8'h03, 0};
    vecs[8]  = '{255, 8'h00, 8'h00, 510};
    vecs[9]  = '{255, 8'h00, 8'h04, 382};
    vecs[10] = '{255, 8'h01, 8'h01, 510};
    vecs[11] = '{255, 8'h02, 8'h0D, 32};
    strobeExp = '{0, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 4};

    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;

    // Idle after reset: everything stays silent.
    doReset();
    for (int i = 0; i < 10; i++) begin
      repeat (100) tick();
      checkOutput("quietSample", sample_out, 0);
      checkOutput("quietPdm", pdm_out, 0);
    end

    // Fastest octave, period 0: saw ramps one per cycle and wraps at 256.
    doReset();
    applyStimulus(6'd1, 8'd7);
    applyStimulus(6'd2, 8'h80);
    for (int k = 1; k <= 300; k++) begin
      tick();
      checkOutput("sawRamp", sample_out, (k - 1) % 256);
    end

    // Phase reset mid-count with period 5, then writes to nonexistent voices 4 and 5.
    doReset();
    applyStimulus(6'd1, 8'd7);
    applyStimulus(6'd0, 8'd5);
    repeat (9) tick();
    applyStimulus(6'd2, 8'h80);
    for (int idx = 0; idx < 20; idx++) begin
      if (idx == 8) applyStimulus(6'd18, 8'h80);
      else if (idx == 9) applyStimulus(6'd22, 8'h80);
      else if (idx == 10) applyStimulus(6'd21, 8'd7);
      else tick();
      checkOutput($sformatf("strobeSeq%0d", idx), sample_out, strobeExp[idx]);
    end

    // Octave 6, period 3 square: level flips every 1024 cycles.
    doReset();
    applyStimulus(6'd0, 8'd3);
    applyStimulus(6'd1, 8'd6);
    applyStimulus(6'd2, 8'h81);
    nTrans = 0;
    prevSample = sample_out;
    for (int i = 0; i < 3 ; i++) begin
      edgeTick[i] = -5000;
      edgeLevel[i] = -1;
    end
    for (int i = 0; i < 4000 && nTrans < 3; i++) begin
      tick();
      if (int'(sample_out) != prevSample) begin
        edgeTick[nTrans] = tickCount;
        edgeLevel[nTrans] = sample_out;
        nTrans++;
        prevSample = sample_out;
      end
    end
    checkOutput("squareTransitions", nTrans, 3);
    checkOutput("squareHigh", edgeLevel[0], 255);
    checkOutput("squareLow", edgeLevel[1], 0);
    checkOutput("squareHighPeriod", edgeTick[1] - edgeTick[0], 1024);
    checkOutput("squareLowPeriod", edgeTick[2] - edgeTick[1], 1024);

    // Hold sample_out at 128 for over 512 cycles and count PDM ones.
    doReset();
    applyStimulus(6'd1, 8'd7);
    applyStimulus(6'd2, 8'h80);
    repeat (126) tick();
    applyStimulus(6'd3, 8'h03);
    tick();
    tick();
    checkOutput("pdmLevelStart", sample_out, 128);
    ones = 0;
    for (int i = 0; i < 512; i++) begin
      tick();
      ones += int'(pdm_out);
    end
    checkOutput("pdmLevelEnd", sample_out, 128);
`ifdef SYNTH_PDM_OUT_EN
    expOnes = 128;
`else
    expOnes = 0;
`endif
    checkOutput("pdmDuty", ones, expOnes);

    // Both voices stay in lockstep at octave 0, so phase P is stable between divider wraps.
    doReset();
    for (int i = 0; i < 12; i++) begin
      while (tickCount < 128 * (vecs[i].phase - 1) + 4) tick();
      applyStimulus(6'd2, vecs[i].reg2v0);
      applyStimulus(6'd6, vecs[i].reg2v1);
      tick();
      checkOutput($sformatf("mix%0d", i), sample_out, vecs[i].expSample);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
